// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_OPC,
        S_ARG,
        S_WRITE,
        S_CKSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Default frame start marker.
    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    // Frame layout: header, LEN_BYTES big-endian length bytes, then
    // BYTES_PER_WORD payload bytes per word (opcode first), then checksum.
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 2;

    // An instruction word is exactly one opcode byte plus one argument byte.
    function automatic bit width_ok(input int unsigned dw, input int unsigned iw);
        return iw == BYTES_PER_WORD * dw;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter with synchronous clear and count enable; flags the
// cycle on which the LIMIT-th consecutive enabled cycle occurs.
module loader_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // Count enabled cycles; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/prog_loader.sv
// Host byte-stream loader: parses framed instruction images, writes
// {opcode, arg} words into instruction memory and holds the core until a
// frame with a matching checksum has fully loaded.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH        = 8,
    parameter int unsigned            ADDR_WIDTH        = 12,
    parameter int unsigned            INSTRUCTION_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]  HEADER_BYTE       = HEADER_BYTE_DEFAULT,
    parameter int unsigned            TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        BYTE_IN,
    input  logic                         BYTE_VALID,
    output logic                         BYTE_READY,
    output logic                         MEM_WE,
    output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
    output logic [INSTRUCTION_WIDTH-1:0] MEM_WDATA,
    output logic                         CORE_HOLD,
    output logic                         LOAD_DONE,
    output logic                         LOAD_ERROR,
    output logic [ADDR_WIDTH:0]          WORDS_LOADED
);

    localparam int unsigned LEN_WIDTH = LEN_BYTES * DATA_WIDTH;
    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;

    generate
        if (!width_ok(DATA_WIDTH, INSTRUCTION_WIDTH)) begin : g_width_check
            $error("prog_loader: INSTRUCTION_WIDTH must equal 2*DATA_WIDTH");
        end
    endgenerate

    state_t                  state, state_next;
    logic [LEN_WIDTH-1:0]    len;
    logic [LEN_WIDTH-1:0]    len_full;
    logic [DATA_WIDTH-1:0]   opc, arg, sum;
    logic [ADDR_WIDTH-1:0]   address;
    logic [ADDR_WIDTH:0]     words_loaded, words_next;
    logic                    core_hold, load_error;
    logic                    transfer, counting, timed_out;

    assign BYTE_READY   = !(state inside {S_WRITE, S_DONE, S_ERR});
    assign transfer     = BYTE_VALID && BYTE_READY;
    assign counting     = state inside {S_LEN_HI, S_LEN_LO, S_OPC, S_ARG, S_CKSUM};
    assign len_full     = {len[LEN_WIDTH-1:DATA_WIDTH], BYTE_IN};
    assign words_next   = words_loaded + (ADDR_WIDTH + 1)'(1);

    assign MEM_WE       = (state == S_WRITE);
    assign MEM_ADDR     = address;
    assign MEM_WDATA    = {opc, arg};
    assign CORE_HOLD    = core_hold;
    assign LOAD_DONE    = (state == S_DONE);
    assign LOAD_ERROR   = load_error;
    assign WORDS_LOADED = words_loaded;

    loader_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (reset),
        .clear   (!counting || transfer),
        .enable  (counting && !transfer),
        .expired (timed_out)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: a transfer always takes priority over a timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (transfer && BYTE_IN == HEADER_BYTE) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (transfer)       state_next = S_LEN_LO;
                else if (timed_out) state_next = S_ERR;
            end
            S_LEN_LO: begin
                if (transfer) begin
                    if ({1'b0, len_full} > MAX_LEN) state_next = S_ERR;
                    else if (len_full == '0)        state_next = S_CKSUM;
                    else                            state_next = S_OPC;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_OPC: begin
                if (transfer)       state_next = S_ARG;
                else if (timed_out) state_next = S_ERR;
            end
            S_ARG: begin
                if (transfer)       state_next = S_WRITE;
                else if (timed_out) state_next = S_ERR;
            end
            S_WRITE: begin
                if (LEN_WIDTH'(words_next) == len) state_next = S_CKSUM;
                else                               state_next = S_OPC;
            end
            S_CKSUM: begin
                if (transfer)       state_next = (BYTE_IN == sum) ? S_DONE : S_ERR;
                else if (timed_out) state_next = S_ERR;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Frame datapath: length, opcode/arg latches, running sum, write address,
    // word count and the hold/error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len          <= '0;
            opc          <= '0;
            arg          <= '0;
            sum          <= '0;
            address      <= '0;
            words_loaded <= '0;
            core_hold    <= 1'b1;
            load_error   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (transfer && BYTE_IN == HEADER_BYTE) begin
                        core_hold    <= 1'b1;
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        sum          <= '0;
                        address      <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (transfer) begin
                        len <= {BYTE_IN, {DATA_WIDTH{1'b0}}};
                        sum <= sum + BYTE_IN;
                    end
                end
                S_LEN_LO: begin
                    if (transfer) begin
                        len <= len_full;
                        sum <= sum + BYTE_IN;
                    end
                end
                S_OPC: begin
                    if (transfer) begin
                        opc <= BYTE_IN;
                        sum <= sum + BYTE_IN;
                    end
                end
                S_ARG: begin
                    if (transfer) begin
                        arg <= BYTE_IN;
                        sum <= sum + BYTE_IN;
                    end
                end
                S_WRITE: begin
                    address      <= address + ADDR_WIDTH'(1);
                    words_loaded <= words_next;
                end
                S_DONE: begin
                    core_hold <= 1'b0;
                end
                default: ;
            endcase
            if (state_next == S_ERR) load_error <= 1'b1;
        end
    end

endmodule
